// File: rtl/sensor_sequence_generator_if.sv
// Command/waveform bundle between the pushbutton front end and the sequence generator.
// Defining OCCUPANCY_EN adds the 3-bit occ count to the bundle.
interface sensor_sequence_generator_if;
   logic       start_in;
   logic       start_out;
   logic       a;
   logic       b;
   logic       busy;
   logic       done;
   logic       err;
`ifdef OCCUPANCY_EN
   logic [2:0] occ;

   modport master (output start_in, start_out, input a, b, busy, done, err, occ);
   modport slave  (input start_in, start_out, output a, b, busy, done, err, occ);
`else
   modport master (output start_in, start_out, input a, b, busy, done, err);
   modport slave  (input start_in, start_out, output a, b, busy, done, err);
`endif
endinterface

// File: rtl/sensor_sequence_generator.sv
// Emits the a/b sensor waveform of one car crossing (entry or exit) on command, with a one-deep
// request queue. Optional macro OCCUPANCY_EN adds an occupancy count that vetoes impossible requests.
module sensor_sequence_generator #(
   parameter int unsigned PHASE_CYCLES = 1200000,
   parameter int unsigned CNT_W        = 21
) (
   input  logic                        clk,
   input  logic                        rst,
   sensor_sequence_generator_if.slave  bus
);
   typedef enum logic [2:0] {S_IDLE, S_P1, S_P2, S_P3, S_GAP} state_e;

   localparam logic [CNT_W-1:0] PHASE_LAST = CNT_W'(PHASE_CYCLES - 32'd1);
   localparam logic             DIR_ENTRY  = 1'b0;
   localparam logic             DIR_EXIT   = 1'b1;

   state_e           state_q, state_d;
   logic [CNT_W-1:0] timer_q, timer_d;
   logic             dir_q, dir_d;
   logic             pend_v_q, pend_v_d;
   logic             pend_dir_q, pend_dir_d;
   logic             prev_in_q, prev_out_q;
   logic             a_q, a_d, b_q, b_d;
   logic             busy_q, busy_d, done_q, done_d, err_q, err_d;

   logic             rise_in, rise_out, collide, req, req_dir, blocked, accept;
   logic             phase_end, gap_exit, wave_a, wave_b;

   // A held level is consumed once; both lines rising together is a collision.
   assign rise_in   = bus.start_in  & ~prev_in_q;
   assign rise_out  = bus.start_out & ~prev_out_q;
   assign collide   = bus.start_in & bus.start_out & (rise_in | rise_out);
   assign req       = (rise_in | rise_out) & ~(bus.start_in & bus.start_out);
   assign req_dir   = rise_out ? DIR_EXIT : DIR_ENTRY;
   assign phase_end = (timer_q == PHASE_LAST);
   assign gap_exit  = (state_q == S_GAP) && phase_end;

`ifdef OCCUPANCY_EN
   logic [2:0] occ_q, occ_d;
   logic [3:0] occ_proj;

   // Projected occupancy counts a queued entry as already inside.
   always_comb begin
      occ_proj = {1'b0, occ_q} + {3'b000, (pend_v_q & (pend_dir_q == DIR_ENTRY))};
      blocked  = req && (((req_dir == DIR_EXIT)  && (occ_proj == 4'd0)) ||
                         ((req_dir == DIR_ENTRY) && (occ_proj >= 4'd7)));
      occ_d    = occ_q;
      if (done_q) begin
         if ((dir_q == DIR_EXIT) && (occ_q != 3'd0))       occ_d = occ_q - 3'd1;
         else if ((dir_q == DIR_ENTRY) && (occ_q != 3'd7)) occ_d = occ_q + 3'd1;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) occ_q <= 3'd0;
      else     occ_q <= occ_d;
   end

   assign bus.occ = occ_q;
`else
   assign blocked = 1'b0;
`endif

   always_comb begin
      state_d    = state_q;
      dir_d      = dir_q;
      pend_v_d   = pend_v_q;
      pend_dir_d = pend_dir_q;
      accept     = req & ~blocked;
      err_d      = collide | (req & blocked);
      wave_a     = 1'b0;
      wave_b     = 1'b0;

      case (state_q)
         S_IDLE: if (accept) begin
            state_d = S_P1;
            dir_d   = req_dir;
         end
         S_P1: if (phase_end) state_d = S_P2;
         S_P2: if (phase_end) state_d = S_P3;
         S_P3: if (phase_end) state_d = S_GAP;
         S_GAP: if (phase_end) begin
            if (pend_v_q) begin
               state_d  = S_P1;
               dir_d    = pend_dir_q;
               pend_v_d = 1'b0;
            end else if (accept) begin
               state_d = S_P1;
               dir_d   = req_dir;
            end else begin
               state_d = S_IDLE;
            end
         end
         default: state_d = S_IDLE;
      endcase

      // Requests while running fill the single slot; a request on the last GAP cycle starts directly.
      if ((state_q != S_IDLE) && accept) begin
         if (pend_v_q) begin
            err_d = 1'b1;
         end else if (!gap_exit) begin
            pend_v_d   = 1'b1;
            pend_dir_d = req_dir;
         end
      end

      if ((state_q == S_IDLE) || phase_end) timer_d = '0;
      else                                  timer_d = timer_q + CNT_W'(1);

      case (state_d)
         S_P1:    begin wave_a = 1'b1; wave_b = 1'b0; end
         S_P2:    begin wave_a = 1'b1; wave_b = 1'b1; end
         S_P3:    begin wave_a = 1'b0; wave_b = 1'b1; end
         default: begin wave_a = 1'b0; wave_b = 1'b0; end
      endcase

      a_d    = (dir_d == DIR_EXIT) ? wave_b : wave_a;
      b_d    = (dir_d == DIR_EXIT) ? wave_a : wave_b;
      busy_d = (state_d != S_IDLE);
      done_d = (state_d == S_GAP) && (timer_d == PHASE_LAST);
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q    <= S_IDLE;
         timer_q    <= '0;
         dir_q      <= DIR_ENTRY;
         pend_v_q   <= 1'b0;
         pend_dir_q <= DIR_ENTRY;
         prev_in_q  <= 1'b0;
         prev_out_q <= 1'b0;
         a_q        <= 1'b0;
         b_q        <= 1'b0;
         busy_q     <= 1'b0;
         done_q     <= 1'b0;
         err_q      <= 1'b0;
      end else begin
         state_q    <= state_d;
         timer_q    <= timer_d;
         dir_q      <= dir_d;
         pend_v_q   <= pend_v_d;
         pend_dir_q <= pend_dir_d;
         prev_in_q  <= bus.start_in;
         prev_out_q <= bus.start_out;
         a_q        <= a_d;
         b_q        <= b_d;
         busy_q     <= busy_d;
         done_q     <= done_d;
         err_q      <= err_d;
      end
   end

   assign bus.a    = a_q;
   assign bus.b    = b_q;
   assign bus.busy = busy_q;
   assign bus.done = done_q;
   assign bus.err  = err_q;

endmodule

// File: tb/tb_sensor_sequence_generator.sv
// Vector-table bench for sensor_sequence_generator with PHASE_CYCLES=4; expected outputs are
// queued when each vector is driven and popped when the registered outputs are sampled.
module tb_sensor_sequence_generator;
   localparam int unsigned PHASE = 4;
   localparam int unsigned SEQ   = 4 * PHASE;
   localparam logic [4:0]  IDLE_OUT = 5'b00000;

   typedef struct {
      logic       si;
      logic       so;
      logic [4:0] exp;   // {a, b, busy, done, err}
      string      tag;
   } vec_t;

   logic clk;
   logic rst;
   int   n_vec;
   int   n_fail;
   logic [4:0] exp_q[$];
   vec_t tbl[$];

   sensor_sequence_generator_if bus_if ();

   sensor_sequence_generator #(.PHASE_CYCLES(PHASE), .CNT_W(21)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus_if.slave)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Expected a,b for cycle k of a sequence, taken from the phase table.
   function automatic logic [1:0] phase_ab(input int k, input logic ex);
      logic [1:0] ab;
      case (k / PHASE)
         0:       ab = 2'b10;
         1:       ab = 2'b11;
         2:       ab = 2'b01;
         default: ab = 2'b00;
      endcase
      if (ex) ab = {ab[0], ab[1]};
      return ab;
   endfunction

   function automatic logic [4:0] seq_out(input int k, input logic ex);
      return {phase_ab(k, ex), 1'b1, (k == SEQ - 1), 1'b0};
   endfunction

   function automatic vec_t mk(input logic si, input logic so, input logic [4:0] e, input string tag);
      vec_t v;
      v.si = si; v.so = so; v.exp = e; v.tag = tag;
      return v;
   endfunction

   task automatic check(input string tag, input logic [4:0] got, input logic [4:0] e);
      n_vec++;
      if (got !== e) begin
         n_fail++;
         $display("FAIL %s: a,b,busy,done,err got %b expected %b at %0t", tag, got, e, $time);
      end
   endtask

   task automatic apply(input vec_t v);
      logic [4:0] got;
      logic [4:0] e;
      @(negedge clk);
      bus_if.start_in  = v.si;
      bus_if.start_out = v.so;
      exp_q.push_back(v.exp);
      @(posedge clk);
      #1;
      got = {bus_if.a, bus_if.b, bus_if.busy, bus_if.done, bus_if.err};
      e   = exp_q.pop_front();
      check(v.tag, got, e);
   endtask

   task automatic do_reset();
      bus_if.start_in  = 1'b0;
      bus_if.start_out = 1'b0;
      rst = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      check("reset", {bus_if.a, bus_if.b, bus_if.busy, bus_if.done, bus_if.err}, IDLE_OUT);
      @(negedge clk);
      rst = 1'b0;
   endtask

`ifdef OCCUPANCY_EN
   task automatic check_occ(input string tag, input logic [2:0] e);
      n_vec++;
      if (bus_if.occ !== e) begin
         n_fail++;
         $display("FAIL %s: occ got %0d expected %0d at %0t", tag, bus_if.occ, e, $time);
      end
   endtask
`endif

   initial begin
      #200000;
      $display("FAIL watchdog: bench did not finish in time");
      $fatal(1, "timeout");
   end

   initial begin
      n_vec  = 0;
      n_fail = 0;

      for (int k = 0; k <= SEQ; k++)
         tbl.push_back(mk(k == 0, 1'b0, (k < SEQ) ? seq_out(k, 1'b0) : IDLE_OUT, "entry"));
      for (int k = 0; k <= SEQ; k++)
         tbl.push_back(mk(1'b0, k == 0, (k < SEQ) ? seq_out(k, 1'b1) : IDLE_OUT, "exit"));
      // Held start_in runs once; a fresh edge after a low cycle is accepted again.
      for (int k = 0; k <= 22 + SEQ; k++) begin
         logic [4:0] e;
         if (k < SEQ)            e = seq_out(k, 1'b0);
         else if (k < 22)        e = IDLE_OUT;
         else if (k < 22 + SEQ)  e = seq_out(k - 22, 1'b0);
         else                    e = IDLE_OUT;
         tbl.push_back(mk((k < 20) || (k == 22), 1'b0, e, "held_entry"));
      end
      tbl.push_back(mk(1'b1, 1'b1, 5'b00001, "collide_idle"));
      tbl.push_back(mk(1'b0, 1'b0, IDLE_OUT, "collide_idle_after"));
      for (int k = 0; k <= SEQ; k++) begin
         logic [4:0] e;
         e = (k < SEQ) ? seq_out(k, 1'b0) : IDLE_OUT;
         if (k == 5) e[0] = 1'b1;
         tbl.push_back(mk((k == 0) || (k == 5), k == 5, e, "collide_busy"));
      end
      for (int k = 0; k <= 2 * SEQ; k++) begin
         logic [4:0] e;
         if (k < SEQ)          e = seq_out(k, 1'b0);
         else if (k < 2 * SEQ) e = seq_out(k - SEQ, 1'b1);
         else                  e = IDLE_OUT;
         if (k == 7) e[0] = 1'b1;
         tbl.push_back(mk((k == 0) || (k == 7), k == 6, e, "queued_exit"));
      end

      do_reset();
      for (int i = 0; i < tbl.size(); i++) apply(tbl[i]);

      // Asynchronous reset during P2, then normal acceptance.
      for (int k = 0; k < 6; k++) apply(mk(k == 0, 1'b0, seq_out(k, 1'b0), "rst_mid_pre"));
      @(negedge clk);
      rst = 1'b1;
      #1;
      check("rst_async", {bus_if.a, bus_if.b, bus_if.busy, bus_if.done, bus_if.err}, IDLE_OUT);
      repeat (2) @(posedge clk);
      @(negedge clk);
      rst = 1'b0;
      for (int k = 0; k < 20; k++) apply(mk(1'b0, 1'b0, IDLE_OUT, "rst_mid_quiet"));
      for (int k = 0; k <= SEQ; k++)
         apply(mk(k == 0, 1'b0, (k < SEQ) ? seq_out(k, 1'b0) : IDLE_OUT, "rst_mid_entry"));

`ifdef OCCUPANCY_EN
      do_reset();
      apply(mk(1'b0, 1'b1, 5'b00001, "occ_exit_empty"));
      apply(mk(1'b0, 1'b0, IDLE_OUT, "occ_exit_empty_after"));
      check_occ("occ_zero", 3'd0);
      for (int r = 0; r < 7; r++)
         for (int k = 0; k <= SEQ; k++)
            apply(mk(k == 0, 1'b0, (k < SEQ) ? seq_out(k, 1'b0) : IDLE_OUT, "occ_fill"));
      check_occ("occ_full", 3'd7);
      apply(mk(1'b1, 1'b0, 5'b00001, "occ_entry_full"));
      apply(mk(1'b0, 1'b0, IDLE_OUT, "occ_entry_full_after"));
      for (int k = 0; k <= SEQ; k++)
         apply(mk(1'b0, k == 0, (k < SEQ) ? seq_out(k, 1'b1) : IDLE_OUT, "occ_exit"));
      check_occ("occ_after_exit", 3'd6);
`endif

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
      $finish;
   end
endmodule
